// File: rtl/spram_bank_ctrl.sv
`timescale 1ns/1ps
// SPRAM bank controller: NUM_BANKS banks of SP256K single-port RAM, each with an
// idle-driven SLEEP/WAKE power FSM, one access per cycle, one-cycle read latency.

module spram_bank_ctrl #(
  parameter int NUM_BANKS         = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int IDLE_SLEEP_CYCLES = 1024,
  parameter int WAKE_CYCLES       = 3,
  localparam int AW = 14 + $clog2(NUM_BANKS),
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [AW-1:0]         addr,
  input  logic [BW-1:0]         we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_BANKS-1:0]  bank_sleeping
);

  localparam int SELW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int NPRIM = (DATA_WIDTH + 15) / 16;
  localparam int CW    = (IDLE_SLEEP_CYCLES > 1) ? $clog2(IDLE_SLEEP_CYCLES) : 1;
  localparam int WCW   = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_SLEEP  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

  localparam logic [CW-1:0]  IDLE_LAST = CW'(IDLE_SLEEP_CYCLES - 1);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

  logic [SELW-1:0]                      bank_sel_s;
  logic [SELW-1:0]                      rbank_r;
  logic [NUM_BANKS-1:0]                 sel_s;
  logic [NUM_BANKS-1:0]                 active_s;
  logic [NUM_BANKS-1:0]                 sleep_s;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_do_s;
  logic                                 accept_s;
  logic                                 wr_s;
  logic                                 rvalid_r;

  if (NUM_BANKS > 1) begin : g_sel
    assign bank_sel_s = addr[AW-1:14];
  end else begin : g_nosel
    assign bank_sel_s = 1'b0;
  end

  // One-hot decode of the addressed bank
  always_comb begin
    sel_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_s[b] = (bank_sel_s == SELW'(b));
    end
  end

  assign ready    = |(sel_s & active_s);
  assign accept_s = req & ready & ~reset;
  assign wr_s     = |we;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0]     state_r, state_next_s;
    logic [CW-1:0]  idle_r, idle_next_s;
    logic [WCW-1:0] wake_r, wake_next_s;
    logic           sleep_r;
    logic           hit_s;
    logic           bank_we_s;

    assign hit_s     = req & sel_s[b];
    assign bank_we_s = accept_s & wr_s & sel_s[b];

    // Power FSM next state; a request on the threshold cycle keeps the bank awake
    always_comb begin
      state_next_s = state_r;
      idle_next_s  = idle_r;
      wake_next_s  = wake_r;
      case (state_r)
        ST_ACTIVE: begin
          if (hit_s) begin
            idle_next_s = '0;
          end else if ((IDLE_SLEEP_CYCLES != 0) && (idle_r == IDLE_LAST)) begin
            state_next_s = ST_SLEEP;
            idle_next_s  = '0;
          end else if (idle_r != {CW{1'b1}}) begin
            idle_next_s = idle_r + CW'(1);
          end else begin
            idle_next_s = idle_r;
          end
        end
        ST_SLEEP: begin
          if (hit_s) begin
            idle_next_s  = '0;
            wake_next_s  = '0;
            state_next_s = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
          end else begin
            state_next_s = ST_SLEEP;
          end
        end
        ST_WAKE: begin
          if (hit_s) begin
            idle_next_s = '0;
          end else begin
            idle_next_s = idle_r;
          end
          if (wake_r == WAKE_LAST) begin
            state_next_s = ST_ACTIVE;
            wake_next_s  = '0;
          end else begin
            wake_next_s = wake_r + WCW'(1);
          end
        end
        default: begin
          state_next_s = ST_ACTIVE;
          idle_next_s  = '0;
          wake_next_s  = '0;
        end
      endcase
    end

    // Power FSM state, counters and registered SLEEP pin
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= ST_ACTIVE;
        idle_r  <= '0;
        wake_r  <= '0;
        sleep_r <= 1'b0;
      end else begin
        state_r <= state_next_s;
        idle_r  <= idle_next_s;
        wake_r  <= wake_next_s;
        sleep_r <= (state_next_s == ST_SLEEP);
      end
    end

    assign active_s[b] = (state_r == ST_ACTIVE);
    assign sleep_s[b]  = sleep_r;

    for (genvar p = 0; p < NPRIM; p++) begin : g_prim
      logic [3:0] maskwe_s;
      // Each byte enable covers both nibbles of its byte
      assign maskwe_s = {{2{we[2*p+1]}}, {2{we[2*p]}}};

      SP256K u_spram (
        .AD       (addr[13:0]),
        .DI       (wdata[16*p +: 16]),
        .MASKWE   (maskwe_s),
        .WE       (bank_we_s),
        .CS       (1'b1),
        .CK       (clk),
        .STDBY    (1'b0),
        .SLEEP    (sleep_r),
        .PWROFF_N (1'b1),
        .DO       (bank_do_s[b][16*p +: 16])
      );
    end
  end

  // Read-return tracking: which bank owns the data appearing next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_r <= 1'b0;
      rbank_r  <= '0;
    end else begin
      rvalid_r <= accept_s & ~wr_s;
      rbank_r  <= accept_s ? bank_sel_s : rbank_r;
    end
  end

  assign rvalid        = rvalid_r & ~reset;
  assign bank_sleeping = sleep_s & {NUM_BANKS{~reset}};

  // Return-data mux, forced to zero when no read is returning
  always_comb begin
    rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rdata = rdata | ((rvalid && (rbank_r == SELW'(b))) ? bank_do_s[b] : '0);
    end
  end

endmodule

// Behavioural SP256K (16K x 16, nibble write mask, registered read); the vendor
// cell library version replaces this module in an iCE40UP implementation flow.
module SP256K (
  input  logic [13:0] AD,
  input  logic [15:0] DI,
  input  logic [3:0]  MASKWE,
  input  logic        WE,
  input  logic        CS,
  input  logic        CK,
  input  logic        STDBY,
  input  logic        SLEEP,
  input  logic        PWROFF_N,
  output logic [15:0] DO
);

  logic [15:0] mem [16384];
  logic        en_s;

  assign en_s = CS & ~STDBY & ~SLEEP & PWROFF_N;

  // Masked write or synchronous read of the addressed word
  always_ff @(posedge CK) begin
    if (en_s && WE) begin
      for (int n = 0; n < 4; n++) begin
        if (MASKWE[n]) begin
          mem[AD][n*4 +: 4] <= DI[n*4 +: 4];
        end
      end
    end else if (en_s) begin
      DO <= mem[AD];
    end
  end

endmodule

// File: tb/tb_spram_bank_ctrl.sv
`timescale 1ns/1ps
// Directed bench for spram_bank_ctrl: vector table for data path, hand sequences
// for sleep/wake timing, threshold collision and reset during WAKE.

module tb_spram_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [14:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  bank_sleeping;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spram_bank_ctrl #(
    .NUM_BANKS(2), .DATA_WIDTH(32), .IDLE_SLEEP_CYCLES(1024), .WAKE_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .we(we), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .bank_sleeping(bank_sleeping)
  );

  typedef struct {
    logic        req;
    logic [14:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(input logic r, input logic [14:0] a, input logic [3:0] w,
                              input logic [31:0] d, input logic er, input logic ev,
                              input logic [31:0] ed);
    vec_t t;
    t.req = r; t.addr = a; t.we = w; t.wdata = d;
    t.exp_ready = er; t.exp_rvalid = ev; t.exp_rdata = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [14:0] a, input logic [3:0] w,
                       input logic [31:0] d);
    req = r; addr = a; we = w; wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall;

    vt[0]  = mk(1'b1, 15'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    vt[1]  = mk(1'b1, 15'h0010, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    vt[2]  = mk(1'b1, 15'h0020, 4'hF, 32'h11223344, 1'b1, 1'b1, 32'hDEADBEEF);
    vt[3]  = mk(1'b1, 15'h0020, 4'h9, 32'hAA5566BB, 1'b1, 1'b0, 32'h0);
    vt[4]  = mk(1'b1, 15'h0020, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    vt[5]  = mk(1'b0, 15'h0020, 4'h0, 32'h0,        1'b1, 1'b1, 32'hAA2233BB);
    vt[6]  = mk(1'b1, 15'h4010, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    vt[7]  = mk(1'b1, 15'h4010, 4'h3, 32'h12345678, 1'b1, 1'b0, 32'h0);
    vt[8]  = mk(1'b1, 15'h4010, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    vt[9]  = mk(1'b1, 15'h0010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFE5678);
    vt[10] = mk(1'b1, 15'h4010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF);
    vt[11] = mk(1'b1, 15'h0020, 4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFE5678);
    vt[12] = mk(1'b1, 15'h4010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hAA2233BB);
    vt[13] = mk(1'b1, 15'h0010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFE5678);
    vt[14] = mk(1'b1, 15'h4010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF);
    vt[15] = mk(1'b1, 15'h0020, 4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFE5678);
    vt[16] = mk(1'b1, 15'h4010, 4'h0, 32'h0,        1'b1, 1'b1, 32'hAA2233BB);
    vt[17] = mk(1'b0, 15'h0000, 4'h0, 32'h0,        1'b1, 1'b1, 32'hCAFE5678);
    vt[18] = mk(1'b0, 15'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    vt[19] = mk(1'b1, 15'h4020, 4'hF, 32'h77778888, 1'b1, 1'b0, 32'h0);
    vt[20] = mk(1'b1, 15'h0020, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    vt[21] = mk(1'b0, 15'h0000, 4'h0, 32'h0,        1'b1, 1'b1, 32'hAA2233BB);

    // Reset state
    reset = 1'b1;
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    step();
    #3;
    check("in_reset_rvalid", 32'(rvalid), 32'd0);
    check("in_reset_sleeping", 32'(bank_sleeping), 32'd0);
    step();
    reset = 1'b0;
    #3;
    check("post_reset_ready", 32'(ready), 32'd1);
    check("post_reset_rvalid", 32'(rvalid), 32'd0);
    check("post_reset_rdata", rdata, 32'd0);
    check("post_reset_sleeping", 32'(bank_sleeping), 32'd0);
    step();

    // Data path vectors; expected rvalid/rdata belong to the previous vector's read
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].req, vt[i].addr, vt[i].we, vt[i].wdata);
      #3;
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vt[i].exp_ready));
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vt[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
      step();
    end

    // Bank 1 idles 1024 cycles while bank 0 is read every cycle
    do_reset();
    drive(1'b1, 15'h0010, 4'h0, 32'h0);
    for (int i = 0; i < 1023; i++) step();
    #3;
    check("sleep_1023_idle", 32'(bank_sleeping), 32'd0);
    step();
    #3;
    check("sleep_1024_idle", 32'(bank_sleeping), 32'd2);
    drive(1'b1, 15'h4010, 4'h0, 32'h0);
    stall = 0;
    while (stall < 20) begin
      #3;
      if (ready) break;
      check($sformatf("wake_sleeping_%0d", stall), 32'(bank_sleeping),
            (stall == 0) ? 32'd2 : 32'd0);
      stall++;
      step();
    end
    check("wake_stall_cycles", 32'(stall), 32'd4);
    step();
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    #3;
    check("wake_read_rvalid", 32'(rvalid), 32'd1);
    check("wake_read_rdata", rdata, 32'hCAFE5678);

    // Request to bank 0 on its exact threshold cycle
    do_reset();
    for (int i = 0; i < 1023; i++) step();
    drive(1'b1, 15'h0030, 4'hF, 32'h5A5AA5A5);
    #3;
    check("thresh_ready", 32'(ready), 32'd1);
    step();
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    #3;
    check("thresh_sleeping", 32'(bank_sleeping), 32'd2);
    for (int i = 0; i < 5; i++) step();
    drive(1'b1, 15'h0030, 4'h0, 32'h0);
    #3;
    check("thresh_later_sleeping", 32'(bank_sleeping), 32'd2);
    check("thresh_read_ready", 32'(ready), 32'd1);
    step();
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    #3;
    check("thresh_read_rvalid", 32'(rvalid), 32'd1);
    check("thresh_read_rdata", rdata, 32'h5A5AA5A5);
    step();

    // Reset during WAKE with a stalled read to bank 1
    drive(1'b1, 15'h4010, 4'h0, 32'h0);
    #3;
    check("rstwake_sleep_ready", 32'(ready), 32'd0);
    step();
    #3;
    check("rstwake_wake_ready", 32'(ready), 32'd0);
    check("rstwake_wake_sleeping", 32'(bank_sleeping), 32'd0);
    step();
    reset = 1'b1;
    #3;
    check("rstwake_in_rvalid", 32'(rvalid), 32'd0);
    check("rstwake_in_rdata", rdata, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 15'h4010, 4'h0, 32'h0);
    #3;
    check("rstwake_after_ready", 32'(ready), 32'd1);
    check("rstwake_after_rvalid", 32'(rvalid), 32'd0);
    check("rstwake_after_rdata", rdata, 32'd0);
    check("rstwake_after_sleeping", 32'(bank_sleeping), 32'd0);
    step();
    #3;
    check("rstwake_next_rvalid", 32'(rvalid), 32'd0);
    drive(1'b1, 15'h4010, 4'h0, 32'h0);
    #3;
    check("rstwake_read_ready", 32'(ready), 32'd1);
    step();
    drive(1'b0, 15'h0000, 4'h0, 32'h0);
    #3;
    check("rstwake_read_rvalid", 32'(rvalid), 32'd1);
    check("rstwake_read_rdata", rdata, 32'hCAFE5678);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_bank_ctrl.md
SPRAM_BANK_CTRL -- requirements
Module: spram_bank_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows:
- NUM_BANKS, 2, number of SPRAM banks (1, 2 or 4).
- DATA_WIDTH, 32, word width (16 = one SP256K per bank; 32 = two SP256K side by side per bank).
- IDLE_SLEEP_CYCLES, 1024, idle cycles before a bank sleeps; 0 disables sleep.
- WAKE_CYCLES, 3, cycles a bank stays in WAKE before accepting requests.
REQ-002 Derived widths SHALL be: AW = 14 + clog2(NUM_BANKS); BW = DATA_WIDTH/8.
REQ-003 Ports (name, direction, width, meaning) SHALL be as follows:
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- req, in, 1, access request.
- addr, in, AW, word address; top clog2(NUM_BANKS) bits select the bank.
- we, in, BW, byte write enables; all zero = read.
- wdata, in, DATA_WIDTH, write data.
- ready, out, 1, request accepted this cycle when req && ready.
- rvalid, out, 1, read data valid.
- rdata, out, DATA_WIDTH, read data.
- bank_sleeping, out, NUM_BANKS, per-bank SLEEP status.
REQ-004 The block SHALL use exactly one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-005 Each bank SHALL instantiate ceil(DATA_WIDTH/16) SP256K primitives with CS=1 and PWROFF_N=1; STDBY SHALL be tied 0.
REQ-006 Byte enable we[i] SHALL drive both MASKWE nibbles of byte i in the matching primitive; WE SHALL be asserted only for an accepted request with |we = 1.
REQ-007 Each bank SHALL have its own FSM with states ACTIVE, SLEEP and WAKE.
- ACTIVE -> SLEEP when the idle counter reaches IDLE_SLEEP_CYCLES-1 and no request targets the bank that cycle.
- SLEEP -> WAKE on the cycle after req=1 addresses the bank.
- WAKE -> ACTIVE after WAKE_CYCLES cycles.
REQ-008 The primitive SLEEP pin SHALL be 1 only in the SLEEP state; bank_sleeping[b] SHALL be 1 only in the SLEEP state.
REQ-009 Each bank's idle counter SHALL clear on any cycle in which req targets that bank, and otherwise increment while ACTIVE, saturating.
REQ-010 A request and the sleep threshold landing in the same cycle SHALL resolve as: request wins, bank stays ACTIVE, counter clears.
REQ-011 ready SHALL be combinational and equal 1 iff the addressed bank is ACTIVE; req and ready SHALL have no other dependency.
REQ-012 An accepted read SHALL produce rvalid=1 exactly one cycle later, with rdata taken from the bank registered at accept time.
REQ-013 An accepted write SHALL NOT assert rvalid.
REQ-014 rdata SHALL be all-zero whenever rvalid=0.
REQ-015 Back-to-back accepted reads, including to different banks, SHALL sustain one access per cycle.
REQ-016 A held req to a non-ACTIVE bank SHALL be stalled (ready=0) without loss; the master keeps addr/we/wdata stable until accepted.
REQ-017 With IDLE_SLEEP_CYCLES=0, all banks SHALL stay ACTIVE permanently.

Reset
REQ-018 While reset=1, every bank SHALL go to ACTIVE with its idle counter at 0; rvalid=0, rdata=0, bank_sleeping=0, and no WE is issued.
REQ-019 A reset asserted during WAKE or SLEEP SHALL return the bank to ACTIVE on the next edge; a read pending at reset SHALL be dropped (no rvalid).
REQ-020 ready SHALL equal 1 in the first cycle after reset deasserts.

Verification
REQ-021 Write 0xDEADBEEF, we=4'b1111, addr 0x00010, then read addr 0x00010 -> rvalid one cycle after accept, rdata=0xDEADBEEF.
REQ-022 Write 0x11223344 full word, then write 0xAAxxxxBB with we=4'b1001, then read -> rdata=0xAA2233BB.
REQ-023 Idle bank 1 for 1024 cycles -> bank_sleeping=2'b10; req to bank 1 -> ready=0 for 1+3 cycles, then ready=1, access completes; bank 0 stays ACTIVE throughout.
REQ-024 Alternate reads bank0/bank1 every cycle for 8 cycles -> 8 consecutive rvalid pulses, correct data per bank.
REQ-025 Request to bank 0 on the exact threshold cycle -> bank 0 never sleeps, access is accepted.
REQ-026 Assert reset during WAKE with a read pending -> the bank is ACTIVE after reset, no rvalid, all outputs zero.
